// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - E-stage multiply/divide unit producing the HI/LO registers
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t         r_state, w_next_state;
    logic [CW-1:0]  r_cnt, w_cnt_next;
    logic [63:0]    r_pending;
    logic [31:0]    r_hi, r_lo;
    logic           r_done;
    logic           w_pend_load, w_commit, w_mthi, w_mtlo;

    logic signed [63:0] w_a_sx, w_b_sx;
    logic [63:0]        w_prod_s, w_prod_u, w_result;
    logic               w_sdiv, w_a_neg, w_b_neg;
    logic [31:0]        w_a_mag, w_b_mag, w_q_mag, w_r_mag, w_quo, w_rem;

    assign w_a_sx   = {{32{A[31]}}, A};
    assign w_b_sx   = {{32{B[31]}}, B};
    assign w_prod_s = w_a_sx * w_b_sx;
    assign w_prod_u = {32'd0, A} * {32'd0, B};

    // Signed divide on magnitudes; 0x80000000 / -1 naturally yields LO=0x80000000, HI=0.
    assign w_sdiv  = (op == OP_DIV);
    assign w_a_neg = w_sdiv & A[31];
    assign w_b_neg = w_sdiv & B[31];
    assign w_a_mag = w_a_neg ? -A : A;
    assign w_b_mag = (B == 32'd0) ? 32'd1 : (w_b_neg ? -B : B);
    assign w_q_mag = w_a_mag / w_b_mag;
    assign w_r_mag = w_a_mag % w_b_mag;
    assign w_quo   = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
    assign w_rem   = w_a_neg ? -w_r_mag : w_r_mag;

    always_comb begin
        w_result = {w_rem, w_quo};
        case (op)
            OP_MULT:  w_result = w_prod_s;
            OP_MULTU: w_result = w_prod_u;
            default:  w_result = {w_rem, w_quo};
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_pend_load  = 1'b0;
        w_commit     = 1'b0;
        w_mthi       = 1'b0;
        w_mtlo       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            w_pend_load  = 1'b1;
                            w_cnt_next   = MULT_LOAD;
                            w_next_state = S_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (B != 32'd0) begin
                                w_pend_load  = 1'b1;
                                w_cnt_next   = DIV_LOAD;
                                w_next_state = S_RUN;
                            end
                        end
                        OP_MTHI: w_mthi = 1'b1;
                        OP_MTLO: w_mtlo = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                w_cnt_next = r_cnt - CNT_ONE;
                if (r_cnt == CNT_ONE) begin
                    w_commit     = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_pending <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
            r_done  <= w_commit;
            if (w_pend_load) begin
                r_pending <= w_result;
            end
            if (w_commit) begin
                r_hi <= r_pending[63:32];
                r_lo <= r_pending[31:0];
            end else begin
                if (w_mthi) r_hi <= A;
                if (w_mtlo) r_lo <= A;
            end
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = r_done;
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - randomized self-checking bench for mult_div_unit
module tb_mult_div_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        busy, done;
    logic [31:0] HI, LO;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .busy(busy), .done(done), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit integer arithmetic on the architectural rules.
    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] hi, output logic [31:0] lo);
        longint sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        lat = 0;
        hi = m_hi;
        lo = m_lo;
        case (o)
            3'd1: begin sp = sa * sb; hi = sp[63:32]; lo = sp[31:0]; lat = MC; end
            3'd2: begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; lat = MC; end
            3'd3: if (b != 0) begin sq = sa / sb; sr = sa % sb; hi = sr[31:0]; lo = sq[31:0]; lat = DC; end
            3'd4: if (b != 0) begin up = ua / ub; hi = up[31:0]; up = ua % ub; lo = hi; hi = up[31:0]; lat = DC; end
            3'd5: hi = a;
            3'd6: lo = a;
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int lat;
        logic [31:0] eh, el;
        model(o, a, b, lat, eh, el);
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0;
        check("done_after_start", {63'd0, done}, 64'd0);
        if (lat == 0) begin
            m_hi = eh; m_lo = el;
            check("busy_short", {63'd0, busy}, 64'd0);
            check("hilo_short", {HI, LO}, {m_hi, m_lo});
        end else begin
            check("busy_first", {63'd0, busy}, 64'd1);
            for (int k = 1; k <= lat; k++) begin
                start = 1'($urandom_range(0, 1));
                op = 3'($urandom_range(1, 7));
                A = $urandom; B = $urandom;
                @(posedge clk); #1;
                start = 1'b0;
                if (k < lat) begin
                    check("busy_run", {63'd0, busy}, 64'd1);
                    check("hilo_hold", {HI, LO}, {m_hi, m_lo});
                    check("done_run", {63'd0, done}, 64'd0);
                end
            end
            m_hi = eh; m_lo = el;
            check("busy_end", {63'd0, busy}, 64'd0);
            check("done_pulse", {63'd0, done}, 64'd1);
            check("hilo_commit", {HI, LO}, {m_hi, m_lo});
        end
    endtask

    initial begin
        #2;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_hilo", {HI, LO}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op(3'd1, 32'hFFFFFFFD, 32'd5);
        check("plan_mult", {HI, LO}, 64'hFFFFFFFF_FFFFFFF1);
        @(posedge clk); #1;
        check("done_once", {63'd0, done}, 64'd0);
        run_op(3'd2, 32'hFFFFFFFF, 32'd2);
        check("plan_multu", {HI, LO}, 64'h00000001_FFFFFFFE);
        run_op(3'd3, 32'hFFFFFFF9, 32'd2);
        check("plan_div", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
        run_op(3'd5, 32'h1234, 32'd0);
        run_op(3'd6, 32'h5678, 32'd0);
        run_op(3'd4, 32'hABCD, 32'd0);
        check("plan_div0", {HI, LO}, 64'h00001234_00005678);
        run_op(3'd3, 32'd100, 32'd7);
        check("plan_div_ign", {HI, LO}, 64'h00000002_0000000E);
        run_op(3'd3, 32'h80000000, 32'hFFFFFFFF);
        check("plan_ovf", {HI, LO}, 64'h00000000_80000000);

        for (int n = 0; n < 40; n++) begin
            logic [2:0]  ro;
            logic [31:0] ra, rb;
            ro = 3'($urandom_range(0, 7));
            ra = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'hFFFFFFFF;
                2: rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            run_op(ro, ra, rb);
        end

        @(negedge clk);
        start = 1'b1; op = 3'd1; A = 32'd3; B = 32'd4;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        m_hi = 32'd0; m_lo = 32'd0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_hilo", {HI, LO}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < MC + 2; k++) begin
            @(posedge clk); #1;
            check("post_rst_done", {63'd0, done}, 64'd0);
            check("post_rst_hilo", {HI, LO}, 64'd0);
        end
        run_op(3'd2, 32'd6, 32'd7);
        check("post_rst_mult", {HI, LO}, 64'd42);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multiply/divide unit in the E stage: the producer of the HI/LO values that forwarding delivers to D, E and M as the HI/LO sources. It accepts one operation per `start` pulse and holds `busy` for a fixed multi-cycle latency. It then commits the result to the HI/LO registers. The stall controller reads `start | busy` to hold back any following multiply/divide instruction in D.

## Interface
Parameters:
- MULT_CYCLES, 5, cycles from accepted MULT/MULTU to HI/LO commit (≥1)
- DIV_CYCLES, 10, cycles from accepted DIV/DIVU to HI/LO commit (≥1)

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low; clears all state immediately
- start  input  1  operation request from E stage, sampled at clk rising edge
- op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (NONE)
- A  input  32  forwarded rs value (already MF_ALUA-selected)
- B  input  32  forwarded rt value (already MF_ALUB-selected)
- busy  output  1  operation in flight; HI/LO not yet committed
- done  output  1  one-cycle pulse in the cycle after commit
- HI  output  32  HI register
- LO  output  32  LO register

## Operation
- Reset (reset=0, async): HI=0, LO=0, busy=0, done=0, counter=0, pending result cleared.
- State machine, 2 states:
  - IDLE: busy=0.
  - RUN: busy=1; the down-counter holds the remaining cycles.
- Accept rule: `start` is accepted only in IDLE.
  - `start` while busy=1 is ignored entirely: no latch, no counter reload, no HI/LO write.
- IDLE, start, op=MULT/MULTU:
  - latch the 64-bit product of A and B into a pending register;
  - load counter=MULT_CYCLES and go to RUN.
- IDLE, start, op=DIV/DIVU, B≠0:
  - latch quotient→pending LO and remainder→pending HI;
  - load counter=DIV_CYCLES and go to RUN.
- IDLE, start, op=DIV/DIVU, B=0: operation dropped; HI/LO unchanged, busy stays 0, no done pulse.
- IDLE, start, op=MTHI: HI←A at that edge; busy stays 0; no done.
- IDLE, start, op=MTLO: LO←A at that edge; busy stays 0; no done.
- IDLE, start, op=NONE or 7: no effect.
- RUN: counter decrements each edge. At the edge where counter goes 1→0:
  - {HI,LO} ← pending;
  - return to IDLE (busy=0);
  - done=1 for exactly the following cycle.
- Arithmetic:
  - MULT: signed 32×32→64; HI = product[63:32], LO = product[31:0].
  - MULTU: unsigned 32×32→64.
  - DIV: signed; quotient truncates toward zero; remainder has the sign of the dividend.
  - DIV overflow case A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0.
  - DIVU: unsigned.
- HI/LO change only at a commit edge, an MTHI/MTLO edge, or reset; they never change mid-operation.

## Timing
- Start accepted at edge t:
  - busy=1 from after edge t to edge t+N (N = MULT_CYCLES or DIV_CYCLES), i.e. busy is high for exactly N cycles;
  - HI/LO show the new value after edge t+N;
  - done=1 during cycle t+N → t+N+1.
- Back-to-back: a start presented in the same cycle that busy falls (after edge t+N) is accepted at edge t+N+1.
- MTHI/MTLO latency: 1 edge; the new value is visible on HI/LO in the next cycle.
- Reset asserted mid-RUN aborts the operation:
  - pending result discarded; HI/LO=0, busy=0, done=0 immediately, without waiting for clk.
- Release of reset (0→1) takes effect with no spurious done or commit; the first start is accepted at the first rising edge with reset=1.
- HI/LO are register outputs with no combinational path from A/B/op/start. busy is a register output; the stall controller ORs in `start` itself.

## Test plan
- MULT, A=0xFFFFFFFD (−3), B=5:
  - busy high for exactly 5 cycles;
  - after edge t+5: HI=0xFFFFFFFF, LO=0xFFFFFFF1;
  - done pulses once.
- MULTU, A=0xFFFFFFFF, B=2: after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
- DIV, A=0xFFFFFFF9 (−7), B=2: busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU with B=0, after MTHI A=0x1234 and MTLO A=0x5678:
  - HI=0x1234, LO=0x5678 remain unchanged;
  - busy never rises; done never pulses.
- Start DIV (A=100, B=7), then in cycle 3 of RUN issue MULT and MTHI (A=0xDEAD):
  - both ignored;
  - after 10 cycles: LO=14, HI=2.
- Start MULT, A=3, B=4; assert reset=0 mid-cycle at cycle 2:
  - busy=0 and HI=LO=0 before the next edge;
  - after release, no done pulse and HI/LO stay 0.
